// File: rtl/obe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : obe_pkg
//  Brief    : Shared encodings for the order book engine (sides, FSM states,
//             default slot field widths).
//  Revision : 1.0 - initial release
// ============================================================================
package obe_pkg;

   // Aggressor / resting side encoding
   localparam logic SIDE_BUY  = 1'b0;
   localparam logic SIDE_SELL = 1'b1;

   // FSM state encoding, exported on the state port for the display
   localparam int         STATE_W     = 2;
   localparam logic [1:0] C_ST_IDLE   = 2'd0;
   localparam logic [1:0] C_ST_MATCH  = 2'd1;
   localparam logic [1:0] C_ST_REST   = 2'd2;
   localparam logic [1:0] C_ST_HALT   = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = C_ST_IDLE,
      ST_MATCH = C_ST_MATCH,
      ST_REST  = C_ST_REST,
      ST_HALT  = C_ST_HALT
   } state_t;

   // Default widths of one resting-order slot record (price + quantity)
   localparam int DEF_PRICE_W = 8;
   localparam int DEF_QTY_W   = 8;

endpackage
`default_nettype wire

// File: rtl/best_price_sel.sv
`default_nettype none
// ============================================================================
//  Module   : best_price_sel
//  Brief    : Combinational best-price search over one side of the book.
//             MODE 0 selects the maximum price, MODE 1 the minimum. Ties go
//             to the lowest slot index. Reports 0 / index 0 when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module best_price_sel #(
   parameter int PRICE_W = 8,
   parameter int DEPTH   = 8,
   parameter bit MODE    = 1'b0,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid,
   input  logic [DEPTH*PRICE_W-1:0] prices,
   output logic [PRICE_W-1:0]       best,
   output logic [IDX_W-1:0]         best_idx,
   output logic                     any_valid
);

   logic [PRICE_W-1:0] w_p;
   logic               w_better;

   // Linear scan; only a strictly better price replaces the current pick
   always_comb begin
      best      = '0;
      best_idx  = '0;
      any_valid = 1'b0;
      w_p       = '0;
      w_better  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_p      = prices[i*PRICE_W +: PRICE_W];
         w_better = (MODE == 1'b0) ? (w_p > best) : (w_p < best);
         if (valid[i] && (!any_valid || w_better)) begin
            best      = w_p;
            best_idx  = IDX_W'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/order_book_engine.sv
`default_nettype none
// ============================================================================
//  Module   : order_book_engine
//  Brief    : DEPTH-slot-per-side limit order book. Aggressor orders are
//             matched one fill per cycle against the best resting price;
//             any remainder rests in the lowest free slot of its own side.
//  Revision : 1.0 - initial release
// ============================================================================
module order_book_engine
   import obe_pkg::*;
#(
   parameter int PRICE_W    = DEF_PRICE_W,
   parameter int QTY_W      = DEF_QTY_W,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 8,
   parameter int MAX_TRADES = 255,
   localparam int CW        = $clog2(DEPTH+1),
   localparam int IW        = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_side,
   input  logic [PRICE_W-1:0] in_price,
   input  logic [QTY_W-1:0]   in_qty,
   output logic               trade_valid,
   output logic [PRICE_W-1:0] trade_price,
   output logic [QTY_W-1:0]   trade_qty,
   output logic               trade_side,
   output logic               reject,
   output logic [PRICE_W-1:0] best_bid,
   output logic [PRICE_W-1:0] best_ask,
   output logic               bid_valid,
   output logic               ask_valid,
   output logic [PRICE_W-1:0] spread_now,
   output logic [CW-1:0]      bid_count,
   output logic [CW-1:0]      ask_count,
   output logic [CNT_W-1:0]   trade_count,
   output logic               halt,
   output logic [1:0]         state
);

   state_t r_state, w_next_state;

   // Book storage
   logic [DEPTH-1:0]   r_bid_vld, r_ask_vld;
   logic [PRICE_W-1:0] r_bid_price [DEPTH];
   logic [PRICE_W-1:0] r_ask_price [DEPTH];
   logic [QTY_W-1:0]   r_bid_qty   [DEPTH];
   logic [QTY_W-1:0]   r_ask_qty   [DEPTH];

   // Latched aggressor
   logic               r_agg_side;
   logic [PRICE_W-1:0] r_agg_price;
   logic [QTY_W-1:0]   r_agg_qty;

   // Registered outputs
   logic               r_trade_valid, r_trade_side, r_reject;
   logic [PRICE_W-1:0] r_trade_price;
   logic [QTY_W-1:0]   r_trade_qty;
   logic [CNT_W-1:0]   r_trade_count;

   // Combinational helpers
   logic [DEPTH*PRICE_W-1:0] w_bid_flat, w_ask_flat;
   logic [PRICE_W-1:0]       w_best_bid, w_best_ask;
   logic [IW-1:0]            w_bid_idx, w_ask_idx;
   logic                     w_bid_any, w_ask_any;
   logic [CW-1:0]            w_bid_cnt, w_ask_cnt;
   logic                     w_cross;
   logic [PRICE_W-1:0]       w_match_price;
   logic [QTY_W-1:0]         w_slot_qty, w_fill;
   logic [CNT_W-1:0]         w_count_inc;
   logic                     w_last_trade, w_agg_done;
   logic [DEPTH-1:0]         w_own_vld;
   logic                     w_free_found;
   logic [IW-1:0]            w_free_idx;

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_flat
         assign w_bid_flat[g*PRICE_W +: PRICE_W] = r_bid_price[g];
         assign w_ask_flat[g*PRICE_W +: PRICE_W] = r_ask_price[g];
      end
   endgenerate

   best_price_sel #(.PRICE_W(PRICE_W), .DEPTH(DEPTH), .MODE(1'b0)) u_bid_sel (
      .valid     (r_bid_vld),
      .prices    (w_bid_flat),
      .best      (w_best_bid),
      .best_idx  (w_bid_idx),
      .any_valid (w_bid_any)
   );

   best_price_sel #(.PRICE_W(PRICE_W), .DEPTH(DEPTH), .MODE(1'b1)) u_ask_sel (
      .valid     (r_ask_vld),
      .prices    (w_ask_flat),
      .best      (w_best_ask),
      .best_idx  (w_ask_idx),
      .any_valid (w_ask_any)
   );

   // Occupancy count per side
   always_comb begin
      w_bid_cnt = '0;
      w_ask_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_bid_cnt = w_bid_cnt + CW'(r_bid_vld[i]);
         w_ask_cnt = w_ask_cnt + CW'(r_ask_vld[i]);
      end
   end

   // Crossing test and fill size against the opposite side's best slot
   always_comb begin
      w_cross       = 1'b0;
      w_slot_qty    = '0;
      w_match_price = '0;
      if (r_agg_side == SIDE_BUY) begin
         w_cross       = w_ask_any && (r_agg_price >= w_best_ask);
         w_slot_qty    = r_ask_qty[w_ask_idx];
         w_match_price = w_best_ask;
      end else begin
         w_cross       = w_bid_any && (r_agg_price <= w_best_bid);
         w_slot_qty    = r_bid_qty[w_bid_idx];
         w_match_price = w_best_bid;
      end
      w_fill       = (r_agg_qty < w_slot_qty) ? r_agg_qty : w_slot_qty;
      w_agg_done   = (r_agg_qty == w_fill);
      w_count_inc  = r_trade_count + CNT_W'(1);
      w_last_trade = (w_count_inc == CNT_W'(MAX_TRADES));
   end

   // Lowest-index free slot on the aggressor's own side
   always_comb begin
      w_own_vld    = (r_agg_side == SIDE_BUY) ? r_bid_vld : r_ask_vld;
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!w_own_vld[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = IW'(i);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // FSM next-state and handshake output
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && (in_qty != '0)) w_next_state = ST_MATCH;
         end
         ST_MATCH: begin
            if (w_cross) begin
               if (w_last_trade)    w_next_state = ST_HALT;
               else if (w_agg_done) w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_REST;
            end
         end
         ST_REST: w_next_state = ST_IDLE;
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Book, aggressor and trade/reject registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bid_vld     <= '0;
         r_ask_vld     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_bid_price[i] <= '0;
            r_ask_price[i] <= '0;
            r_bid_qty[i]   <= '0;
            r_ask_qty[i]   <= '0;
         end
         r_agg_side    <= SIDE_BUY;
         r_agg_price   <= '0;
         r_agg_qty     <= '0;
         r_trade_valid <= 1'b0;
         r_trade_price <= '0;
         r_trade_qty   <= '0;
         r_trade_side  <= 1'b0;
         r_reject      <= 1'b0;
         r_trade_count <= '0;
      end else begin
         r_trade_valid <= 1'b0;
         r_reject      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_agg_side  <= in_side;
                  r_agg_price <= in_price;
                  r_agg_qty   <= in_qty;
                  if (in_qty == '0) r_reject <= 1'b1;
               end
            end
            ST_MATCH: begin
               if (w_cross) begin
                  r_trade_valid <= 1'b1;
                  r_trade_price <= w_match_price;
                  r_trade_qty   <= w_fill;
                  r_trade_side  <= r_agg_side;
                  r_trade_count <= w_count_inc;
                  r_agg_qty     <= r_agg_qty - w_fill;
                  if (r_agg_side == SIDE_BUY) begin
                     r_ask_qty[w_ask_idx] <= w_slot_qty - w_fill;
                     if (w_slot_qty == w_fill) r_ask_vld[w_ask_idx] <= 1'b0;
                  end else begin
                     r_bid_qty[w_bid_idx] <= w_slot_qty - w_fill;
                     if (w_slot_qty == w_fill) r_bid_vld[w_bid_idx] <= 1'b0;
                  end
               end
            end
            ST_REST: begin
               if (!w_free_found) begin
                  r_reject <= 1'b1;
               end else if (r_agg_side == SIDE_BUY) begin
                  r_bid_vld[w_free_idx]   <= 1'b1;
                  r_bid_price[w_free_idx] <= r_agg_price;
                  r_bid_qty[w_free_idx]   <= r_agg_qty;
               end else begin
                  r_ask_vld[w_free_idx]   <= 1'b1;
                  r_ask_price[w_free_idx] <= r_agg_price;
                  r_ask_qty[w_free_idx]   <= r_agg_qty;
               end
            end
            default: ;
         endcase
      end
   end

   assign trade_valid = r_trade_valid;
   assign trade_price = r_trade_price;
   assign trade_qty   = r_trade_qty;
   assign trade_side  = r_trade_side;
   assign reject      = r_reject;
   assign trade_count = r_trade_count;
   assign best_bid    = w_best_bid;
   assign best_ask    = w_best_ask;
   assign bid_valid   = w_bid_any;
   assign ask_valid   = w_ask_any;
   assign bid_count   = w_bid_cnt;
   assign ask_count   = w_ask_cnt;
   assign spread_now  = (w_bid_any && w_ask_any) ? (w_best_ask - w_best_bid) : '0;
   assign halt        = (r_state == ST_HALT);
   assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_order_book_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_order_book_engine
//  Brief    : Directed self-checking bench for order_book_engine
//             (MAX_TRADES reduced to 3 so the halt path is reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_order_book_engine;

   localparam int PRICE_W    = 8;
   localparam int QTY_W      = 8;
   localparam int DEPTH      = 8;
   localparam int CNT_W      = 8;
   localparam int MAX_TRADES = 3;
   localparam int CW         = $clog2(DEPTH+1);

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               in_side = 1'b0;
   logic [PRICE_W-1:0] in_price = '0;
   logic [QTY_W-1:0]   in_qty = '0;
   logic               trade_valid;
   logic [PRICE_W-1:0] trade_price;
   logic [QTY_W-1:0]   trade_qty;
   logic               trade_side;
   logic               reject;
   logic [PRICE_W-1:0] best_bid, best_ask, spread_now;
   logic               bid_valid, ask_valid;
   logic [CW-1:0]      bid_count, ask_count;
   logic [CNT_W-1:0]   trade_count;
   logic               halt;
   logic [1:0]         state;

   int n_tests = 0;
   int n_fail  = 0;

   order_book_engine #(
      .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH),
      .CNT_W(CNT_W), .MAX_TRADES(MAX_TRADES)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_side(in_side),
      .in_price(in_price), .in_qty(in_qty),
      .trade_valid(trade_valid), .trade_price(trade_price),
      .trade_qty(trade_qty), .trade_side(trade_side), .reject(reject),
      .best_bid(best_bid), .best_ask(best_ask),
      .bid_valid(bid_valid), .ask_valid(ask_valid),
      .spread_now(spread_now), .bid_count(bid_count), .ask_count(ask_count),
      .trade_count(trade_count), .halt(halt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one order for a single cycle; returns 1ns after the accept edge
   task automatic send(input logic side, input logic [7:0] price, input logic [7:0] qty);
      in_valid = 1'b1;
      in_side  = side;
      in_price = price;
      in_qty   = qty;
      step();
      in_valid = 1'b0;
   endtask

   // Non-crossing order: accept, MATCH (no cross), REST -> back in IDLE
   task automatic rest_order(input logic side, input logic [7:0] price, input logic [7:0] qty);
      send(side, price, qty);
      step();
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      // ---------------- 1: reset and idle ----------------
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_trade_valid", 32'(trade_valid), 0);
         chk("idle_reject", 32'(reject), 0);
      end
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_state", 32'(state), 0);
      chk("rst_best_bid", 32'(best_bid), 0);
      chk("rst_best_ask", 32'(best_ask), 0);
      chk("rst_bid_valid", 32'(bid_valid), 0);
      chk("rst_ask_valid", 32'(ask_valid), 0);
      chk("rst_spread", 32'(spread_now), 0);
      chk("rst_bid_count", 32'(bid_count), 0);
      chk("rst_ask_count", 32'(ask_count), 0);
      chk("rst_trade_count", 32'(trade_count), 0);
      chk("rst_halt", 32'(halt), 0);
      chk("rst_trade_price", 32'(trade_price), 0);
      chk("rst_trade_qty", 32'(trade_qty), 0);

      // ---------------- 2: buy 100x5 rests ----------------
      rest_order(1'b0, 8'd100, 8'd5);
      chk("t2_state", 32'(state), 0);
      chk("t2_best_bid", 32'(best_bid), 100);
      chk("t2_bid_valid", 32'(bid_valid), 1);
      chk("t2_bid_count", 32'(bid_count), 1);
      chk("t2_spread", 32'(spread_now), 0);
      chk("t2_trade_count", 32'(trade_count), 0);

      // ---------------- 3: sell 90x3 partially fills the bid ----------------
      send(1'b1, 8'd90, 8'd3);
      chk("t3_no_trade_yet", 32'(trade_valid), 0);
      chk("t3_in_ready_match", 32'(in_ready), 0);
      step();
      chk("t3_trade_valid", 32'(trade_valid), 1);
      chk("t3_trade_price", 32'(trade_price), 100);
      chk("t3_trade_qty", 32'(trade_qty), 3);
      chk("t3_trade_side", 32'(trade_side), 1);
      chk("t3_trade_count", 32'(trade_count), 1);
      chk("t3_state_idle", 32'(state), 0);
      step();
      chk("t3_pulse_end", 32'(trade_valid), 0);
      chk("t3_bid_count", 32'(bid_count), 1);
      chk("t3_best_bid", 32'(best_bid), 100);

      // ---------------- 4: sweep two bid levels, remainder rests ----------------
      do_reset();
      rest_order(1'b0, 8'd100, 8'd2);
      rest_order(1'b0, 8'd98, 8'd4);
      chk("t4_bid_count_pre", 32'(bid_count), 2);
      chk("t4_best_bid_pre", 32'(best_bid), 100);
      send(1'b1, 8'd95, 8'd8);
      chk("t4_no_trade_yet", 32'(trade_valid), 0);
      step();
      chk("t4_f1_valid", 32'(trade_valid), 1);
      chk("t4_f1_price", 32'(trade_price), 100);
      chk("t4_f1_qty", 32'(trade_qty), 2);
      chk("t4_f1_count", 32'(trade_count), 1);
      chk("t4_f1_best_bid", 32'(best_bid), 98);
      step();
      chk("t4_f2_valid", 32'(trade_valid), 1);
      chk("t4_f2_price", 32'(trade_price), 98);
      chk("t4_f2_qty", 32'(trade_qty), 4);
      chk("t4_f2_side", 32'(trade_side), 1);
      chk("t4_f2_count", 32'(trade_count), 2);
      step();
      chk("t4_rest_state", 32'(state), 2);
      chk("t4_rest_no_trade", 32'(trade_valid), 0);
      step();
      chk("t4_state_idle", 32'(state), 0);
      chk("t4_bid_count", 32'(bid_count), 0);
      chk("t4_bid_valid", 32'(bid_valid), 0);
      chk("t4_ask_count", 32'(ask_count), 1);
      chk("t4_best_ask", 32'(best_ask), 95);
      chk("t4_spread", 32'(spread_now), 0);

      // ---------------- 5: full side and zero-qty rejects ----------------
      do_reset();
      for (int i = 0; i < DEPTH; i++) rest_order(1'b0, 8'(10 + i), 8'd1);
      chk("t5_bid_count_full", 32'(bid_count), 8);
      chk("t5_best_bid_full", 32'(best_bid), 17);
      send(1'b0, 8'd5, 8'd1);
      chk("t5_reject_early0", 32'(reject), 0);
      step();
      chk("t5_reject_early1", 32'(reject), 0);
      step();
      chk("t5_reject_full", 32'(reject), 1);
      chk("t5_state_after_reject", 32'(state), 0);
      step();
      chk("t5_reject_pulse_end", 32'(reject), 0);
      chk("t5_bid_count_kept", 32'(bid_count), 8);
      chk("t5_best_bid_kept", 32'(best_bid), 17);
      send(1'b0, 8'd50, 8'd0);
      chk("t5_reject_zero", 32'(reject), 1);
      chk("t5_zero_state", 32'(state), 0);
      chk("t5_zero_ready", 32'(in_ready), 1);
      step();
      chk("t5_zero_pulse_end", 32'(reject), 0);
      chk("t5_zero_bid_count", 32'(bid_count), 8);

      // ---------------- 6: halt after MAX_TRADES fills ----------------
      do_reset();
      rest_order(1'b1, 8'd51, 8'd1);
      rest_order(1'b1, 8'd50, 8'd1);
      rest_order(1'b1, 8'd52, 8'd1);
      chk("t6_ask_count", 32'(ask_count), 3);
      chk("t6_best_ask", 32'(best_ask), 50);
      send(1'b0, 8'd60, 8'd5);
      step();
      chk("t6_f1_price", 32'(trade_price), 50);
      chk("t6_f1_side", 32'(trade_side), 0);
      step();
      chk("t6_f2_price", 32'(trade_price), 51);
      chk("t6_f2_valid", 32'(trade_valid), 1);
      step();
      chk("t6_f3_price", 32'(trade_price), 52);
      chk("t6_f3_count", 32'(trade_count), 3);
      chk("t6_halt", 32'(halt), 1);
      chk("t6_state_halt", 32'(state), 3);
      chk("t6_in_ready", 32'(in_ready), 0);
      chk("t6_ask_count_empty", 32'(ask_count), 0);
      in_valid = 1'b1;
      in_side  = 1'b1;
      in_price = 8'd40;
      in_qty   = 8'd1;
      repeat (3) step();
      in_valid = 1'b0;
      chk("t6_frozen_state", 32'(state), 3);
      chk("t6_frozen_ask_count", 32'(ask_count), 0);
      chk("t6_frozen_count", 32'(trade_count), 3);
      chk("t6_frozen_trade", 32'(trade_valid), 0);
      chk("t6_frozen_reject", 32'(reject), 0);

      // ---------------- 6b: asynchronous reset mid-MATCH ----------------
      do_reset();
      rest_order(1'b1, 8'd50, 8'd1);
      rest_order(1'b1, 8'd51, 8'd1);
      send(1'b0, 8'd60, 8'd5);
      chk("t6b_in_match", 32'(state), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6b_async_state", 32'(state), 0);
      chk("t6b_async_ready", 32'(in_ready), 1);
      chk("t6b_async_ask_count", 32'(ask_count), 0);
      chk("t6b_async_trade_count", 32'(trade_count), 0);
      chk("t6b_async_trade_valid", 32'(trade_valid), 0);
      chk("t6b_async_halt", 32'(halt), 0);
      #1 reset = 1'b0;
      step();
      chk("t6b_post_ready", 32'(in_ready), 1);
      chk("t6b_post_trade", 32'(trade_valid), 0);
      chk("t6b_post_ask_valid", 32'(ask_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/order_book_engine.md
Name: order_book_engine

Overview:
- Parametrised successor to the single-pair matching_engine: holds up to DEPTH resting orders per side (price + quantity).
- Accepts aggressor orders over a valid/ready handshake and matches them against the book with partial fills, emitting one trade pulse per fill.
- Feeds controller_fsm, counter, spread and display_hex with best bid/ask, spread, trade count and halt.
- Sits between order_generator and the analytics/display blocks.

Parameters:
PRICE_W, 8, price width in bits (unsigned)
QTY_W, 8, quantity width in bits (unsigned)
DEPTH, 8, resting-order slots per side (>=2)
CNT_W, 8, trade_count width
MAX_TRADES, 255, trade count at which the engine halts (<= 2^CNT_W-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  incoming order valid
in_ready  out  1  engine can accept an order this cycle
in_side  in  1  0 = buy, 1 = sell
in_price  in  PRICE_W  limit price
in_qty  in  QTY_W  order quantity
trade_valid  out  1  one-cycle pulse per fill
trade_price  out  PRICE_W  fill price (resting order's price)
trade_qty  out  QTY_W  fill quantity
trade_side  out  1  aggressor side of the fill
reject  out  1  one-cycle pulse: order dropped (book full or qty 0)
best_bid / best_ask  out  PRICE_W  highest bid / lowest ask (0 when side empty)
bid_valid / ask_valid  out  1  side non-empty
spread_now  out  PRICE_W  best_ask-best_bid if both valid, else 0
bid_count / ask_count  out  clog2(DEPTH+1)  occupied slots per side
trade_count  out  CNT_W  fills since reset
halt  out  1  trade_count reached MAX_TRADES
state  out  2  FSM state for display

Behaviour:
- Reset (async, any state incl. mid-MATCH): all slots invalid, state IDLE, trade_valid/reject/halt 0, trade_* 0, trade_count 0; derived outputs then read 0.
- States: IDLE=0, MATCH=1, REST=2, HALT=3.
- IDLE: in_ready=1. On in_valid&in_ready, latch side/price/qty. If qty=0, pulse reject next cycle and stay IDLE; otherwise go to MATCH.
- MATCH (in_ready=0), one fill per cycle. Crossing test:
  - buy: ask_valid && agg_price >= best_ask
  - sell: bid_valid && agg_price <= best_bid
- On cross:
  - fill = min(agg_qty, slot_qty); slot_qty -= fill; slot freed when it reaches 0; agg_qty -= fill.
  - trade_valid/price/qty/side registered, visible the cycle after the MATCH cycle.
  - trade_count += 1. If it now equals MAX_TRADES, set halt and go to HALT, discarding any remainder.
  - Else if agg_qty = 0, go to IDLE; else stay in MATCH.
- No cross: go to REST.
- Latency: accept edge T -> first trade_valid in cycle T+2; consecutive fills produce back-to-back pulses.
- REST: write remainder into the lowest-index free slot of its own side and go to IDLE. If that side is full, pulse reject and go to IDLE.
- HALT: in_ready=0; book frozen; exits only via reset.
- Best selection is combinational over registered slots:
  - max price for bids, min price for asks.
  - Ties go to the lowest slot index (slot-index priority, not time priority).
  - Book updates are visible on best_*/counts the cycle after the write.
- Invariant: the book is never crossed at rest, so spread_now is non-negative. No arithmetic wraps.
- trade_count never exceeds MAX_TRADES.
- Inputs are ignored while in_ready=0; a held in_valid is taken on the next IDLE cycle.

Decomposition:
- Package obe_pkg: side encoding (SIDE_BUY=0, SIDE_SELL=1), state encoding localparams, slot record widths.
- Sub-module best_price_sel: parameters PRICE_W, DEPTH, MODE (0 = max, 1 = min). Inputs: valid vector + price array. Outputs: best price, index, any_valid. Instantiated once per side.

Test Plan:
1. Reset, then idle 5 cycles -> in_ready=1; all outputs 0; no pulses.
2. Buy 100x5 -> no trade; best_bid=100, bid_valid=1, bid_count=1, spread_now=0.
3. With bid 100x5, sell 90x3 -> one trade (price 100, qty 3, side 1) at T+2; bid 100x2 remains; trade_count=1.
4. Bids 100x2 and 98x4 (slots 0,1), sell 95x8 -> back-to-back trades (100,2) and (98,4); ask 95x2 rests; bid_count=0; best_ask=95; spread_now=0.
5. DEPTH=8, eight non-crossing buys 10..17, then ninth buy 5 -> reject pulse; bid_count stays 8; best_bid=17. Also in_qty=0 -> reject.
6. MAX_TRADES=3: three fills -> halt=1, state=3, in_ready=0, later orders ignored. Reset asserted mid-MATCH -> all cleared and in_ready=1 next cycle.
